data_mem_responder: RTL

Memory-side responder for the CPU data port. It accepts load/store requests carrying a byte address, store data already placed on its byte lanes, and a 4-bit per-byte write strobe, and serves them from an internal word-organised RAM. Accesses take a configurable number of wait states and complete with a one-cycle acknowledge. It is the other end of the load/store alignment unit: that unit produces lane-aligned write data and strobes and consumes the raw 32-bit read word, then selects bytes and sign-extends itself.

---
 rtl/data_mem_responder.sv | 104 ++++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
// Data-port memory responder: word-organised RAM with byte-lane strobes,
// a programmable number of wait states and a one-cycle acknowledge.
//
// Handshake: a request is accepted on the rising edge where i_valid && o_ready.
// The requester holds its request until then. o_ack pulses for one cycle per
// accepted request. o_err and o_data_rd are meaningful while o_ack is high.
module data_mem_responder #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_STATES = 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_data_wr,
    input  logic [3:0]  i_we,
    input  logic        i_rd,
    output logic        o_ack,
    output logic        o_err,
    output logic [31:0] o_data_rd
);

    typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;

    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    state_t      state;
    logic [3:0]  wait_cnt;
    logic [31:2] addr_q;
    logic [31:0] data_q;
    logic [3:0]  we_q;
    logic        rd_q;

    logic [31:0] mem [2**ADDR_WIDTH];

    logic [ADDR_WIDTH-1:0] word_idx;
    logic                  in_range;
    logic                  ram_we;
    logic                  unused_addr_bits;

    assign word_idx         = addr_q[ADDR_WIDTH+1:2];
    assign in_range         = (addr_q[31:ADDR_WIDTH+2] == '0);
    assign o_ready          = (state == IDLE);
    assign unused_addr_bits = ^i_addr[1:0];

    // A reset in the ACCESS cycle must suppress the write.
    assign ram_we = (state == ACCESS) && !i_rst && in_range;

    always_ff @(posedge i_clk) begin
        for (int n = 0; n < 4; n++) begin
            if (ram_we && we_q[n]) begin
                mem[word_idx][8*n +: 8] <= data_q[8*n +: 8];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= IDLE;
            wait_cnt  <= 4'd0;
            o_ack     <= 1'b0;
            o_err     <= 1'b0;
            o_data_rd <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        addr_q <= i_addr[31:2];
                        data_q <= i_data_wr;
                        we_q   <= i_we;
                        rd_q   <= i_rd;
                        if (WAIT_STATES == 0) begin
                            state <= ACCESS;
                        end else begin
                            wait_cnt <= WAIT_LOAD;
                            state    <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        state <= ACCESS;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                ACCESS: begin
                    // Read happens on the same edge as the write, so it sees the old word.
                    o_ack     <= 1'b1;
                    o_err     <= !in_range;
                    o_data_rd <= (rd_q && in_range) ? mem[word_idx] : 32'h0;
                    state     <= RESP;
                end
                RESP: begin
                    o_ack <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
